// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: N-lane round-robin writer and burst reader sharing one FIFO.
// Optional PKT_LOCK_EN adds req_last and holds the grant for a whole packet.
module fifo_share_ctrl #(
    parameter int N     = 4,
    parameter int BW_D  = 8,
    parameter int BW_A  = 10,
    parameter int BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    input  logic [N*BW_D-1:0] req_data,
`ifdef PKT_LOCK_EN
    input  logic [N-1:0]      req_last,
`endif
    output logic [N-1:0]      req_ready,
    output logic [BW_D-1:0]   fifo_wr_di,
    output logic              fifo_wr_en,
    input  logic              fifo_wr_rdy,
    output logic              fifo_rd_en,
    input  logic [BW_D-1:0]   fifo_rd_do,
    input  logic              burst_req,
    output logic              burst_ack,
    output logic              out_valid,
    output logic [BW_D-1:0]   out_data,
    output logic              out_last,
    output logic [BW_A:0]     occupancy,
    output logic              busy
);

    localparam int DEPTH = 1 << BW_A;
    localparam int PW    = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = $clog2(BURST + 1);
    localparam logic [BW_A:0] DEPTH_C = (BW_A + 1)'(DEPTH);
    localparam logic [BW_A:0] BURST_C = (BW_A + 1)'(BURST);
    localparam logic [CW-1:0] BEATS_C = CW'(BURST);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] beat_q;
    logic          out_valid_q;
    logic          out_last_q;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [BW_A:0] count_q, count_d;
    logic [PW-1:0] gnt_idx;
    logic          gnt_found;
    logic [PW:0]   cand_w;
    logic [PW-1:0] cand;
    logic          wr_ok;
    logic          wr_xfer;
    logic          rd_en;

`ifdef PKT_LOCK_EN
    logic lock_q, lock_d;
`endif

    // Round-robin scan starting just after the last granted lane.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand_w    = '0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            cand_w = {1'b0, ptr_q} + (PW + 1)'(i);
            if (cand_w >= (PW + 1)'(N)) begin
                cand_w = cand_w - (PW + 1)'(N);
            end
            cand = cand_w[PW-1:0];
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
`ifdef PKT_LOCK_EN
        if (lock_q) begin
            gnt_idx   = ptr_q;
            gnt_found = req_valid[ptr_q];
        end
`endif
    end

    assign wr_ok   = reset & fifo_wr_rdy & (count_q < DEPTH_C);
    assign wr_xfer = gnt_found & wr_ok;
    assign rd_en   = (state_q == READ);

    // Write-port mux and one-hot ready for the granted lane.
    always_comb begin
        req_ready  = '0;
        fifo_wr_di = '0;
        if (wr_xfer) begin
            req_ready[gnt_idx] = 1'b1;
            fifo_wr_di = req_data[gnt_idx*BW_D +: BW_D];
        end
    end

    assign fifo_wr_en = wr_xfer;
    assign fifo_rd_en = rd_en;
    assign burst_ack  = reset & (state_q == IDLE) & burst_req
                      & (count_q >= BURST_C);
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_valid_q ? fifo_rd_do : '0;
    assign occupancy  = count_q;
    assign busy       = (state_q != IDLE);

    // Next pointer, lock and occupancy from this cycle's transfers.
    always_comb begin
        ptr_d = wr_xfer ? gnt_idx : ptr_q;
        unique case ({wr_xfer, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
`ifdef PKT_LOCK_EN
        lock_d = wr_xfer ? ~req_last[gnt_idx] : lock_q;
`endif
    end

    // Arbiter pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= PW'(N - 1);
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

`ifdef PKT_LOCK_EN
    // Packet lock holds the grant until the lane's last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    // Burst FSM; output valid/last trail rd_en by the FIFO read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= rd_en;
            out_last_q  <= rd_en & (beat_q == ONE_C);
            unique case (state_q)
                IDLE: begin
                    if (burst_ack) begin
                        beat_q  <= BEATS_C;
                        state_q <= READ;
                    end
                end
                READ: begin
                    beat_q <= beat_q - ONE_C;
                    if (beat_q == ONE_C) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
